// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with byte/half/word access.
// Hits complete combinationally in IDLE; misses stall via busywait while the FSM refills the line.
module data_cache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    read,
  input  logic [2:0]    write,
  input  logic [31:0]   address,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          busywait,
  output logic          misaligned,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_address,
  output logic [127:0]  mem_writedata,
  input  logic [127:0]  mem_readdata,
  input  logic          mem_busywait
);

  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t state, next_state;

  logic [SETS-1:0]       valid, dirty;
  logic [TAG_W-1:0]      tags  [SETS];
  logic [127:0]          lines [SETS];
  logic [127:0]          fill_block;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [31:0]           sel_word;
  logic                  load_en, store_en, access, hit, idle_hit, load_hit, store_hit;

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] offs,
                                              input logic [2:0] funct3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[{offs, 3'b000} +: 8];
    h = offs[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'h0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] merge_store(input logic [127:0] line, input logic [1:0] word_sel,
                                               input logic [1:0] offs, input logic [1:0] size,
                                               input logic [31:0] data);
    logic [31:0] w;
    w = line[{word_sel, 5'b00000} +: 32];
    case (size)
      2'b00:   w[{offs, 3'b000} +: 8] = data[7:0];
      2'b01:   if (offs[1]) w[31:16] = data[15:0]; else w[15:0] = data[15:0];
      default: w = data;
    endcase
    line[{word_sel, 5'b00000} +: 32] = w;
    return line;
  endfunction

  assign idx      = address[3+INDEX_BITS:4];
  assign tag      = address[31:4+INDEX_BITS];
  assign load_en  = read[3] & ~write[2];
  assign store_en = write[2] & ~read[3];
  assign sel_word = lines[idx][{address[3:2], 5'b00000} +: 32];

  always_comb begin
    misaligned = 1'b0;
    if (load_en) begin
      case (read[2:0])
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = address[0];
        default:        misaligned = |address[1:0];
      endcase
    end else if (store_en) begin
      case (write[1:0])
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = address[0];
        default: misaligned = |address[1:0];
      endcase
    end
  end

  assign access    = (load_en | store_en) & ~misaligned;
  assign hit       = valid[idx] && (tags[idx] == tag);
  assign idle_hit  = (state == IDLE) && hit;
  assign load_hit  = access && load_en && idle_hit;
  assign store_hit = access && store_en && idle_hit;

  // Outputs seen by the pipeline are forced quiet while reset is held
  assign busywait = access && !idle_hit && !reset;
  assign readdata = (load_hit && !reset) ? extend_load(sel_word, address[1:0], read[2:0]) : 32'h0;

  always_comb begin
    next_state    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = address[31:4];
    mem_writedata = lines[idx];
    case (state)
      IDLE: begin
        if (access && !hit)
          next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = {tags[idx], idx};
        if (!mem_busywait) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        if (!mem_busywait) next_state = UPDATE;
      end
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= next_state;
      if (state == UPDATE) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Line/tag storage carries no reset; valid bits alone qualify its contents
  always_ff @(posedge clock) begin
    if (state == ALLOCATE && !mem_busywait)
      fill_block <= mem_readdata;
    if (state == UPDATE) begin
      lines[idx] <= fill_block;
      tags[idx]  <= tag;
    end else if (store_hit) begin
      lines[idx] <= merge_store(lines[idx], address[3:2], address[1:0], write[1:0], writedata);
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller: reference memory, golden byte model and
// scoreboard queues for load results, block fetches and victim writebacks.
module tb_data_cache_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   read;
  logic [2:0]   write;
  logic [31:0]  address, writedata, readdata;
  logic         busywait, misaligned, mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;
  logic         mem_busywait;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  data_cache_controller #(.INDEX_BITS(3)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait), .misaligned(misaligned),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [127:0] mem  [logic [27:0]];
  logic [127:0] gold [logic [27:0]];
  logic [31:0]  exp_data_q [$];
  logic [27:0]  exp_rd_q   [$];
  logic [155:0] exp_wb_q   [$];
  int lat = 0;
  int cnt = 0;

  function automatic logic [127:0] init_blk(input logic [27:0] a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++)
      r[k*32 +: 32] = 32'hDDCCBBAA + 32'h01010101 * 32'(k) + ({4'b0, a} << 8) - 32'h400;
    return r;
  endfunction

  function automatic logic [127:0] mem_blk(input logic [27:0] a);
    return mem.exists(a) ? mem[a] : init_blk(a);
  endfunction

  function automatic logic [127:0] gold_blk(input logic [27:0] a);
    return gold.exists(a) ? gold[a] : init_blk(a);
  endfunction

  function automatic logic [31:0] gold_load(input logic [31:0] a, input logic [2:0] f3);
    logic [127:0] b;
    logic [31:0]  w, s;
    b = gold_blk(a[31:4]);
    w = b[{a[3:2], 5'b00000} +: 32];
    s = w >> {a[1:0], 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic gold_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [127:0] b;
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    b = gold_blk(a[31:4]);
    for (int i = 0; i < n; i++)
      b[int'(a[3:2]) * 32 + (int'(a[1:0]) + i) * 8 +: 8] = d[i*8 +: 8];
    gold[a[31:4]] = b;
  endtask

  // Block memory: busy for lat cycles per request, completes on the first edge with busywait low
  always @(negedge clock) begin
    mem_busywait = (mem_read || mem_write) && (cnt < lat);
    mem_readdata = mem_blk(mem_address);
  end

  always @(posedge clock) begin
    if (mem_read || mem_write) begin
      check_eq("mem_excl", {127'h0, mem_read & mem_write}, 128'h0);
      if (!mem_busywait) begin
        if (mem_write) begin
          if (exp_wb_q.size() == 0) check_eq("wb_unexpected", {100'h0, mem_address}, 128'h0);
          else begin
            logic [155:0] e;
            e = exp_wb_q.pop_front();
            check_eq("wb_addr", {100'h0, mem_address}, {100'h0, e[155:128]});
            check_eq("wb_data", mem_writedata, e[127:0]);
          end
          mem[mem_address] = mem_writedata;
        end else begin
          if (exp_rd_q.size() == 0) check_eq("rd_unexpected", {100'h0, mem_address}, 128'h0);
          else check_eq("rd_addr", {100'h0, mem_address}, {100'h0, exp_rd_q.pop_front()});
        end
        cnt = 0;
      end else cnt++;
    end else cnt = 0;
  end

  task automatic do_access(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                           input logic [31:0] a, input logic [31:0] d,
                           output int stalls, output int rds, output int wrs);
    bit done;
    read = rd; write = wr; address = a; writedata = d;
    if (rd[3]) exp_data_q.push_back(gold_load(a, rd[2:0]));
    stalls = 0; rds = 0; wrs = 0; done = 0;
    while (!done) begin
      @(negedge clock);
      if (!busywait) done = 1;
      else begin
        stalls++;
        rds += int'(mem_read);
        wrs += int'(mem_write);
        if (stalls > 100) begin
          check_eq({tag, "_timeout"}, 128'h1, 128'h0);
          done = 1;
        end
      end
    end
    if (rd[3] && exp_data_q.size() > 0) check_eq(tag, {96'h0, readdata}, {96'h0, exp_data_q.pop_front()});
    if (wr[2]) gold_store(a, wr[1:0], d);
    @(posedge clock); #1;
    read = 4'h0; write = 3'h0;
  endtask

  task automatic mis_check(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                           input logic [31:0] a, input logic exp_mis);
    read = rd; write = wr; address = a; writedata = 32'hFFFFFFFF;
    @(negedge clock);
    check_eq({tag, "_mis"}, {127'h0, misaligned}, {127'h0, exp_mis});
    check_eq({tag, "_busy"}, {127'h0, busywait}, 128'h0);
    check_eq({tag, "_rdata"}, {96'h0, readdata}, 128'h0);
    @(posedge clock); #1;
    read = 4'h0; write = 3'h0;
  endtask

  int st, r, w, hit_stalls;
  logic [127:0] saved;

  initial begin
    reset = 1'b1; read = 4'b1010; write = 3'h0; address = 32'h40; writedata = 32'h0;
    mem_busywait = 1'b0; mem_readdata = '0;
    @(negedge clock);
    check_eq("rst_busy", {127'h0, busywait}, 128'h0);
    check_eq("rst_mem_read", {127'h0, mem_read}, 128'h0);
    check_eq("rst_mem_write", {127'h0, mem_write}, 128'h0);
    check_eq("rst_rdata", {96'h0, readdata}, 128'h0);
    @(posedge clock); #1;
    reset = 1'b0; read = 4'h0;

    exp_rd_q.push_back(28'h4);
    do_access("t1_lw40", 4'b1010, 3'b000, 32'h40, 32'h0, st, r, w);
    check_eq("t1_stalls", 128'(st), 128'd3);
    check_eq("t1_alloc_cycles", 128'(r), 128'd1);
    check_eq("t1_wb_cycles", 128'(w), 128'd0);
    check_eq("t1_word0", {96'h0, gold_load(32'h40, 3'b010)}, {96'h0, 32'hDDCCBBAA});

    hit_stalls = 0;
    do_access("t2_sb41", 4'b0000, 3'b100, 32'h41, 32'h000000F0, st, r, w); hit_stalls += st;
    do_access("t2_lb41", 4'b1000, 3'b000, 32'h41, 32'h0, st, r, w); hit_stalls += st;
    check_eq("t2_lb_value", {96'h0, gold_load(32'h41, 3'b000)}, {96'h0, 32'hFFFFFFF0});
    do_access("t2_lbu41", 4'b1100, 3'b000, 32'h41, 32'h0, st, r, w); hit_stalls += st;
    do_access("t2_lh42", 4'b1001, 3'b000, 32'h42, 32'h0, st, r, w); hit_stalls += st;
    do_access("t2_lhu42", 4'b1101, 3'b000, 32'h42, 32'h0, st, r, w); hit_stalls += st;
    do_access("t2_sh46", 4'b0000, 3'b101, 32'h46, 32'hABCD9234, st, r, w); hit_stalls += st;
    do_access("t2_lw44", 4'b1010, 3'b000, 32'h44, 32'h0, st, r, w); hit_stalls += st;
    do_access("t2_lh46", 4'b1001, 3'b000, 32'h46, 32'h0, st, r, w); hit_stalls += st;
    do_access("t2_sw48", 4'b0000, 3'b110, 32'h48, 32'h8BADF00D, st, r, w); hit_stalls += st;
    do_access("t2_lw48", 4'b1010, 3'b000, 32'h48, 32'h0, st, r, w); hit_stalls += st;
    do_access("t2_lb4b", 4'b1000, 3'b000, 32'h4B, 32'h0, st, r, w); hit_stalls += st;
    do_access("t2_lw4c_f7", 4'b1111, 3'b000, 32'h4C, 32'h0, st, r, w); hit_stalls += st;
    check_eq("t2_hit_stalls", 128'(hit_stalls), 128'd0);

    exp_wb_q.push_back({28'h4, gold_blk(28'h4)});
    exp_rd_q.push_back(28'h14);
    do_access("t3_lw140", 4'b1010, 3'b000, 32'h140, 32'h0, st, r, w);
    check_eq("t3_stalls", 128'(st), 128'd4);
    check_eq("t3_wb_cycles", 128'(w), 128'd1);
    check_eq("t3_alloc_cycles", 128'(r), 128'd1);
    exp_rd_q.push_back(28'h4);
    do_access("t3_lw40_back", 4'b1010, 3'b000, 32'h40, 32'h0, st, r, w);
    check_eq("t3_back_wb_cycles", 128'(w), 128'd0);
    do_access("t3_lw48_back", 4'b1010, 3'b000, 32'h48, 32'h0, st, r, w);
    check_eq("t3_lw48_stalls", 128'(st), 128'd0);

    lat = 5;
    exp_rd_q.push_back(28'h8);
    do_access("t4_lw80", 4'b1010, 3'b000, 32'h80, 32'h0, st, r, w);
    check_eq("t4_stalls", 128'(st), 128'd8);
    check_eq("t4_alloc_cycles", 128'(r), 128'd6);
    lat = 0;

    mis_check("t5_lh43", 4'b1001, 3'b000, 32'h43, 1'b1);
    mis_check("t5_lhu41", 4'b1101, 3'b000, 32'h41, 1'b1);
    mis_check("t5_sw42", 4'b0000, 3'b110, 32'h42, 1'b1);
    mis_check("t5_sh45", 4'b0000, 3'b101, 32'h45, 1'b1);
    mis_check("t5_both", 4'b1010, 3'b110, 32'h40, 1'b0);
    do_access("t5_lw40", 4'b1010, 3'b000, 32'h40, 32'h0, st, r, w);
    check_eq("t5_lw40_stalls", 128'(st), 128'd0);
    exp_rd_q.push_back(28'h14);
    do_access("t5_lw140", 4'b1010, 3'b000, 32'h140, 32'h0, st, r, w);
    check_eq("t5_clean_wb_cycles", 128'(w), 128'd0);
    check_eq("t5_clean_stalls", 128'(st), 128'd3);

    saved = gold_blk(28'h14);
    do_access("t6_sb141", 4'b0000, 3'b100, 32'h141, 32'h0000005A, st, r, w);
    check_eq("t6_sb_stalls", 128'(st), 128'd0);
    lat = 3;
    read = 4'b1010; write = 3'h0; address = 32'h40;
    @(negedge clock);
    check_eq("t6_miss_busy", {127'h0, busywait}, 128'h1);
    @(negedge clock);
    check_eq("t6_wb_active", {127'h0, mem_write}, 128'h1);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_busy", {127'h0, busywait}, 128'h0);
    @(posedge clock); #1;
    reset = 1'b0; read = 4'h0;
    @(negedge clock);
    check_eq("t6_post_mem_write", {127'h0, mem_write}, 128'h0);
    check_eq("t6_post_mem_read", {127'h0, mem_read}, 128'h0);
    check_eq("t6_post_busy", {127'h0, busywait}, 128'h0);
    @(posedge clock); #1;
    gold[28'h14] = saved;
    lat = 0;
    exp_rd_q.push_back(28'h4);
    do_access("t6_lw40", 4'b1010, 3'b000, 32'h40, 32'h0, st, r, w);
    check_eq("t6_lw40_stalls", 128'(st), 128'd3);
    check_eq("t6_lw40_wb_cycles", 128'(w), 128'd0);
    exp_rd_q.push_back(28'h14);
    do_access("t6_lb141_lost", 4'b1000, 3'b000, 32'h141, 32'h0, st, r, w);

    check_eq("rd_q_empty", 128'(exp_rd_q.size()), 128'd0);
    check_eq("wb_q_empty", 128'(exp_wb_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
